// File: rtl/dispatch_pkg.sv
// rtl/dispatch_pkg.sv - shared state encoding, routine base table and defaults for the dispatcher
package dispatch_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_ISSUE  = 3'd3,
    S_EXEC   = 3'd4,
    S_STOP   = 3'd5
  } state_t;

  localparam logic [4:0] HALT_OPCODE = 5'd0;
  localparam int DEFAULT_MAX_ROUTINE_CYCLES = 8;

  // Entry 0 is unused because opcode 0 halts before any lookup is issued.
  localparam logic [5:0] ROUTINE_BASE [32] = '{
    6'd0,  6'd4,  6'd8,  6'd12, 6'd14, 6'd16, 6'd18, 6'd21,
    6'd24, 6'd27, 6'd30, 6'd33, 6'd36, 6'd37, 6'd38, 6'd39,
    6'd40, 6'd41, 6'd42, 6'd43, 6'd44, 6'd45, 6'd46, 6'd47,
    6'd48, 6'd49, 6'd50, 6'd51, 6'd52, 6'd54, 6'd55, 6'd56
  };

endpackage

// File: rtl/routine_rom.sv
// rtl/routine_rom.sv - combinational opcode to microroutine start address lookup
module routine_rom
  import dispatch_pkg::*;
(
  input  logic [4:0] opcode_i,
  output logic [5:0] base_o
);

  assign base_o = ROUTINE_BASE[opcode_i];

endmodule

// File: rtl/microcode_dispatcher.sv
// rtl/microcode_dispatcher.sv - fetch/decode/issue FSM handing opcodes to a microcode sequencer
module microcode_dispatcher
  import dispatch_pkg::*;
#(
  parameter int MAX_ROUTINE_CYCLES = DEFAULT_MAX_ROUTINE_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [7:0] imem_data,
  input  logic       routine_done,
  output logic [7:0] pc,
  output logic [5:0] IRIn,
  output logic       start,
  output logic [4:0] opcode,
  output logic       halted,
  output logic       fault
);

  localparam int CNT_W = $clog2(MAX_ROUTINE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(MAX_ROUTINE_CYCLES - 1);

  state_t           state_q;
  logic [7:0]       pc_q;
  logic [5:0]       irin_q;
  logic             start_q;
  logic [4:0]       opcode_q;
  logic             halted_q;
  logic             fault_q;
  logic [CNT_W-1:0] cnt_q;
  logic [5:0]       rom_base;

  routine_rom u_rom (
    .opcode_i (imem_data[4:0]),
    .base_o   (rom_base)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      irin_q   <= '0;
      start_q  <= 1'b0;
      opcode_q <= '0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (run && !halted_q) state_q <= S_FETCH;
        S_FETCH: state_q <= S_DECODE;
        S_DECODE: begin
          opcode_q <= imem_data[4:0];
          if (imem_data[7:5] != 3'd0) begin
            fault_q  <= 1'b1;
            halted_q <= 1'b1;
            state_q  <= S_STOP;
          end else if (imem_data[4:0] == HALT_OPCODE) begin
            halted_q <= 1'b1;
            state_q  <= S_STOP;
          end else begin
            irin_q  <= rom_base;
            start_q <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt_q   <= '0;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          // Completion is tested first so a done on the final allowed cycle is not a timeout.
          if (routine_done) begin
            start_q <= 1'b0;
            pc_q    <= pc_q + 8'd1;
            state_q <= run ? S_FETCH : S_IDLE;
          end else if (cnt_q == LAST_CYCLE) begin
            start_q  <= 1'b0;
            fault_q  <= 1'b1;
            halted_q <= 1'b1;
            state_q  <= S_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_STOP: state_q <= S_STOP;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pc     = pc_q;
  assign IRIn   = irin_q;
  assign start  = start_q;
  assign opcode = opcode_q;
  assign halted = halted_q;
  assign fault  = fault_q;

endmodule

// File: tb/tb_microcode_dispatcher.sv
// tb/tb_microcode_dispatcher.sv - scoreboard bench for the microcode dispatcher
module tb_microcode_dispatcher;
  import dispatch_pkg::*;

  localparam int MAXC = 8;
  localparam int EV_DISP = 0;
  localparam int EV_DONE = 1;
  localparam int EV_STOP = 2;

  typedef struct {
    int kind;
    int pc;
    int irin;
    int op;
    int fault;
    int len;
    int st;
  } ev_t;

  logic       clk;
  logic       rst;
  logic       run;
  logic       run_en;
  logic       drop_flag;
  logic [7:0] imem_data;
  logic       routine_done;
  logic [7:0] pc;
  logic [5:0] IRIn;
  logic       start;
  logic [4:0] opcode;
  logic       halted;
  logic       fault;

  logic [7:0] mem [256];
  int         base_tbl [32] = '{0, 4, 8, 12, 14, 16, 18, 21, 24, 27, 30, 33, 36, 37, 38, 39,
                                40, 41, 42, 43, 44, 45, 46, 47, 48, 49, 50, 51, 52, 54, 55, 56};
  int         plan_delay [$];
  int         plan_drop [$];
  ev_t        exp_q [$];
  int         mdl_idx;
  int         drv_idx;
  int         vectors = 0;
  int         miscompares = 0;

  assign run = run_en && !drop_flag;

  microcode_dispatcher #(.MAX_ROUTINE_CYCLES(MAXC)) dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .imem_data    (imem_data),
    .routine_done (routine_done),
    .pc           (pc),
    .IRIn         (IRIn),
    .start        (start),
    .opcode       (opcode),
    .halted       (halted),
    .fault        (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) imem_data <= mem[pc];

  function automatic void chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic void push_ev(input int kind, input int p, input int irin, input int op,
                                  input int f, input int len, input int st);
    ev_t e;
    e.kind = kind; e.pc = p; e.irin = irin; e.op = op;
    e.fault = f; e.len = len; e.st = st;
    exp_q.push_back(e);
  endfunction

  // Reference model: walk the program instruction by instruction from pc0.
  task automatic predict(input int pc0);
    int p;
    int d;
    int dr;
    logic [7:0] ins;
    p = pc0;
    for (int guard = 0; guard < 1000; guard++) begin
      ins = mem[p];
      if (ins[7:5] != 3'd0) begin
        push_ev(EV_STOP, p, 0, int'(ins[4:0]), 1, 0, 0);
        return;
      end
      if (ins[4:0] == 5'd0) begin
        push_ev(EV_STOP, p, 0, 0, 0, 0, 0);
        return;
      end
      push_ev(EV_DISP, p, base_tbl[ins[4:0]], int'(ins[4:0]), 0, 0, 0);
      d  = plan_delay[mdl_idx];
      dr = plan_drop[mdl_idx];
      mdl_idx++;
      if (d > MAXC) begin
        push_ev(EV_STOP, p, 0, int'(ins[4:0]), 1, MAXC + 1, 0);
        return;
      end
      p = (p + 1) % 256;
      push_ev(EV_DONE, p, 0, 0, 0, d + 1, dr != 0 ? int'(S_IDLE) : int'(S_FETCH));
      if (dr != 0) return;
    end
  endtask

  // Sequencer model: pulses routine_done a planned number of cycles after start rises.
  initial begin
    int cnt;
    logic armed, drop_pend, ps;
    armed = 0; drop_pend = 0; ps = 0; cnt = 0;
    routine_done = 1'b0; drop_flag = 1'b0; drv_idx = 0;
    forever begin
      @(negedge clk);
      routine_done = 1'b0;
      if (rst) begin
        armed = 0; drop_pend = 0; ps = 0; drv_idx = 0; drop_flag = 1'b0;
      end else begin
        if (!run_en) drop_flag = 1'b0;
        if (drop_pend) begin
          drop_flag = 1'b1;
          drop_pend = 0;
        end
        if (armed) begin
          cnt--;
          if (cnt == 0) begin
            routine_done = 1'b1;
            armed = 0;
          end
        end
        if (start && !ps) begin
          if (drv_idx < plan_delay.size()) begin
            cnt = plan_delay[drv_idx];
            drop_pend = (plan_drop[drv_idx] != 0);
            armed = 1;
          end
          drv_idx++;
        end
        ps = start;
      end
    end
  end

  // Monitor: turns output transitions into events and checks them against the queue.
  initial begin
    logic ps, ph;
    int len;
    int cur_irin;
    int cur_pc;
    ev_t e;
    ps = 0; ph = 0; len = 0; cur_irin = 0; cur_pc = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        ps = 0; ph = 0; len = 0;
      end else begin
        if ((halted && !ph) || (!start && ps) || (start && !ps)) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_event: start=%0d halted=%0d pc=%0d with nothing expected",
                     start, halted, pc);
          end else begin
            e = exp_q.pop_front();
            if (halted && !ph) begin
              chk("event_kind_stop", EV_STOP, e.kind);
              chk("stop_pc", int'(pc), e.pc);
              chk("stop_opcode", int'(opcode), e.op);
              chk("stop_fault", int'(fault), e.fault);
              chk("stop_start", int'(start), 0);
              chk("stop_start_len", len, e.len);
            end else if (!start && ps) begin
              chk("event_kind_done", EV_DONE, e.kind);
              chk("done_pc", int'(pc), e.pc);
              chk("done_start_len", len, e.len);
              chk("done_state", int'(dut.state_q), e.st);
            end else begin
              chk("event_kind_disp", EV_DISP, e.kind);
              chk("disp_pc", int'(pc), e.pc);
              chk("disp_irin", int'(IRIn), e.irin);
              chk("disp_opcode", int'(opcode), e.op);
              cur_irin = e.irin;
              cur_pc = e.pc;
            end
          end
        end
        if (start && !ps) len = 1;
        else if (start) begin
          len++;
          chk("irin_hold", int'(IRIn), cur_irin);
          chk("pc_hold", int'(pc), cur_pc);
        end else len = 0;
        ps = start;
        ph = halted;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    run_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic new_scenario();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    plan_delay.delete();
    plan_drop.delete();
    exp_q.delete();
    mdl_idx = 0;
    do_reset();
  endtask

  task automatic add_plan(input int d, input int dr);
    plan_delay.push_back(d);
    plan_drop.push_back(dr);
  endtask

  task automatic wait_drain(input int budget, input string name);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int rises;
    logic ps;
    rst = 1'b1;
    run_en = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    new_scenario();
    chk("reset_pc", int'(pc), 0);
    chk("reset_irin", int'(IRIn), 0);
    chk("reset_start", int'(start), 0);
    chk("reset_opcode", int'(opcode), 0);
    chk("reset_halted", int'(halted), 0);
    chk("reset_fault", int'(fault), 0);
    chk("reset_state", int'(dut.state_q), int'(S_IDLE));

    new_scenario();
    mem[0] = 8'h01;
    mem[1] = 8'h00;
    add_plan(3, 0);
    predict(0);
    @(negedge clk);
    run_en = 1'b1;
    wait_drain(200, "basic_drain");

    new_scenario();
    mem[0] = 8'h01;
    for (int k = 1; k < 32; k++) mem[k] = 8'(k);
    mem[32] = 8'h00;
    for (int k = 0; k < 32; k++) add_plan(1, 0);
    predict(0);
    @(negedge clk);
    run_en = 1'b1;
    wait_drain(1000, "sweep_drain");
    chk("sweep_halted", int'(halted), 1);
    chk("sweep_fault", int'(fault), 0);

    new_scenario();
    mem[0] = 8'hE3;
    predict(0);
    @(negedge clk);
    run_en = 1'b1;
    wait_drain(100, "illegal_drain");
    repeat (5) @(negedge clk);
    chk("illegal_start", int'(start), 0);
    chk("illegal_opcode", int'(opcode), 3);

    new_scenario();
    mem[0] = 8'h05;
    add_plan(20, 0);
    predict(0);
    @(negedge clk);
    run_en = 1'b1;
    wait_drain(200, "timeout_drain");
    repeat (30) @(negedge clk);
    chk("timeout_late_state", int'(dut.state_q), int'(S_STOP));
    chk("timeout_late_pc", int'(pc), 0);
    chk("timeout_late_fault", int'(fault), 1);
    chk("timeout_late_start", int'(start), 0);

    new_scenario();
    mem[0] = 8'h07;
    mem[1] = 8'h00;
    add_plan(MAXC, 0);
    predict(0);
    @(negedge clk);
    run_en = 1'b1;
    wait_drain(200, "lastcycle_drain");
    chk("lastcycle_fault", int'(fault), 0);

    new_scenario();
    for (int i = 0; i < 255; i++) mem[i] = {3'b000, 5'($urandom_range(31, 1))};
    mem[255] = 8'h02;
    for (int i = 0; i < 257; i++) add_plan(int'($urandom_range(MAXC, 1)), (i >= 255) ? 1 : 0);
    predict(0);
    @(negedge clk);
    run_en = 1'b1;
    wait_drain(6000, "wrap_drain");
    repeat (4) @(negedge clk);
    chk("wrap_state", int'(dut.state_q), int'(S_IDLE));
    chk("wrap_pc", int'(pc), 0);
    chk("wrap_fault", int'(fault), 0);
    run_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    predict(0);
    run_en = 1'b1;
    wait_drain(200, "resume_drain");
    repeat (4) @(negedge clk);
    chk("resume_pc", int'(pc), 1);
    chk("resume_state", int'(dut.state_q), int'(S_IDLE));

    new_scenario();
    mem[0] = 8'h01;
    mem[1] = 8'h05;
    add_plan(1, 0);
    add_plan(100, 0);
    push_ev(EV_DISP, 0, 4, 1, 0, 0, 0);
    push_ev(EV_DONE, 1, 0, 0, 0, 2, int'(S_FETCH));
    push_ev(EV_DISP, 1, 16, 5, 0, 0, 0);
    @(negedge clk);
    run_en = 1'b1;
    rises = 0;
    ps = start;
    for (int i = 0; i < 200 && rises < 2; i++) begin
      @(negedge clk);
      if (start && !ps) rises++;
      ps = start;
    end
    chk("rstmid_reach", rises, 2);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_start", int'(start), 0);
    chk("rstmid_pc", int'(pc), 0);
    chk("rstmid_irin", int'(IRIn), 0);
    chk("rstmid_opcode", int'(opcode), 0);
    chk("rstmid_state", int'(dut.state_q), int'(S_IDLE));
    chk("rstmid_queue", exp_q.size(), 0);
    @(negedge clk);
    rst = 1'b0;
    run_en = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/microcode_dispatcher.md
MICROCODE_DISPATCHER -- requirements
Module: microcode_dispatcher

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk, rst.
REQ-002 Ports SHALL be:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- run  in  1  dispatch enable, level
- imem_data  in  8  instruction byte, valid the cycle after pc changes (registered read)
- routine_done  in  1  one-cycle pulse from the sequencer on the last micro-step of a routine
- pc  out  8  instruction memory address
- IRIn  out  6  microroutine start address to the sequencer
- start  out  1  sequencer enable
- opcode  out  5  latched opcode of the current instruction
- halted  out  1  sticky; dispatcher has stopped on HALT, illegal or timeout
- fault  out  1  sticky; illegal instruction or routine timeout
REQ-003 Parameter MAX_ROUTINE_CYCLES, default 8: maximum cycles allowed in EXEC before a timeout.

Function
REQ-004 The FSM SHALL have the states IDLE, FETCH, DECODE, ISSUE, EXEC and STOP.
REQ-005 IDLE SHALL move to FETCH when run=1 and halted=0.
REQ-006 FETCH SHALL last one cycle, holding pc stable, then move to DECODE.
REQ-007 DECODE SHALL latch opcode<=imem_data[4:0] and select the next state as follows:
- imem_data[7:5]!=0: illegal; set fault and halted; go to STOP
- opcode 0 (HALT): set halted; go to STOP
- otherwise: IRIn<=ROUTINE_BASE[opcode]; go to ISSUE
REQ-008 ROUTINE_BASE[1..31] SHALL be 4,8,12,14,16,18,21,24,27,30,33,36,37,38,39,40,41,42,43,44,45,46,47,48,49,50,51,52,54,55,56.
REQ-009 ISSUE SHALL assert start=1 for one cycle, then move to EXEC.
REQ-010 In EXEC, start SHALL stay 1 and IRIn SHALL stay stable.
REQ-011 On routine_done in EXEC, start SHALL drop on the next edge, and pc SHALL become pc+1 on that same edge.
REQ-012 After routine_done in EXEC, the next state SHALL be FETCH if run=1, else IDLE.
REQ-013 pc SHALL wrap from 255 to 0 without a fault.
REQ-014 An EXEC cycle counter SHALL clear on entry to EXEC.
REQ-015 If MAX_ROUTINE_CYCLES EXEC cycles elapse without routine_done, the block SHALL set fault and halted, drop start, and go to STOP; pc SHALL be unchanged.
REQ-016 routine_done outside EXEC SHALL be ignored.
REQ-017 If routine_done coincides with the timeout cycle, completion SHALL win.
REQ-018 A run deassertion outside IDLE SHALL take effect only at routine completion; the current instruction always finishes.
REQ-019 STOP SHALL be absorbing and SHALL be left only by rst.
REQ-020 Latency from FETCH entry to start=1 SHALL be 3 cycles (FETCH, DECODE, ISSUE).

Reset
REQ-021 On rst=1 at a clock edge, the block SHALL enter IDLE with pc=0, IRIn=0, start=0, opcode=0, halted=0, fault=0 and the EXEC counter at 0.
REQ-022 rst SHALL override all other inputs in every state, including mid-EXEC, and start SHALL be 0 on the following cycle.

Structure
REQ-023 Package dispatch_pkg SHALL hold the state encoding, ROUTINE_BASE table, HALT_OPCODE=0 and the default MAX_ROUTINE_CYCLES.
REQ-024 The opcode-to-address lookup SHALL be one combinational sub-module, routine_rom (5-bit in, 6-bit out, entry 0 = 0).
REQ-025 RTL size SHALL be 120-400 lines.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Basic dispatch: rst, run=1, imem[0]=8'h01, routine_done 3 cycles after start -> IRIn=4, start high 4 cycles, pc=1, back in FETCH.
- Table sweep: imem[k]=k for k=1..31, done after 1 cycle -> IRIn sequence matches ROUTINE_BASE; imem[32]=0 -> halted=1, fault=0, pc=32.
- Illegal: imem[0]=8'hE3 -> fault=1, halted=1, start never asserted, opcode=3.
- Timeout: opcode 5, routine_done withheld -> after 8 EXEC cycles fault=1, start=0, pc=0; a late routine_done changes nothing.
- run drop and wrap: pc=255, opcode 2, run=0 during EXEC -> on done pc=0, state IDLE; run=1 -> fetch resumes at pc=0.
- Reset mid-EXEC: rst at EXEC cycle 2 -> next cycle start=0, pc=0, IRIn=0, state IDLE.
